// File: rtl/lif_neuron_bank.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons. One shared update
// datapath walks the neurons in index order, one synaptic current per beat.

module lif_update #(
    parameter int V_W  = 16,
    parameter int I_W  = 8,
    parameter int K_W  = 8,
    parameter int RP_W = 4
) (
    input  logic signed [V_W-1:0]  v,
    input  logic        [RP_W-1:0] r,
    input  logic signed [I_W-1:0]  cur,
    input  logic        [K_W-1:0]  k_syn,
    input  logic signed [V_W-1:0]  v_leak,
    input  logic signed [V_W-1:0]  v_rest,
    input  logic signed [V_W-1:0]  v_th,
    input  logic        [RP_W-1:0] rp,
    output logic signed [V_W-1:0]  v_nxt,
    output logic        [RP_W-1:0] r_nxt,
    output logic                   fire
);
    localparam int FW = V_W + K_W + I_W + 2;

    logic signed [FW-1:0]  v_x, k_x, i_x, l_x, sum, sat_max, sat_min;
    logic signed [V_W-1:0] sat, flr;

    always_comb begin
        // widen everything so the sum can never wrap before saturation
        v_x     = {{(FW-V_W){v[V_W-1]}}, v};
        k_x     = {{(FW-K_W){1'b0}}, k_syn};
        i_x     = {{(FW-I_W){cur[I_W-1]}}, cur};
        l_x     = {{(FW-V_W){v_leak[V_W-1]}}, v_leak};
        sum     = v_x + k_x * i_x - l_x;
        sat_max = {{(FW-V_W+1){1'b0}}, {(V_W-1){1'b1}}};
        sat_min = {{(FW-V_W+1){1'b1}}, {(V_W-1){1'b0}}};
        if (sum > sat_max)
            sat = sat_max[V_W-1:0];
        else if (sum < sat_min)
            sat = sat_min[V_W-1:0];
        else
            sat = sum[V_W-1:0];
        flr = (sat < v_rest) ? v_rest : sat;

        v_nxt = flr;
        r_nxt = r;
        fire  = 1'b0;
        if (r != '0) begin
            r_nxt = r - RP_W'(1);
            v_nxt = v_rest;
        end else if (flr >= v_th) begin
            fire  = 1'b1;
            v_nxt = v_rest;
            r_nxt = rp;
        end
    end
endmodule

module lif_neuron_bank #(
    parameter int N    = 2,
    parameter int TS   = 5,
    parameter int V_W  = 16,
    parameter int I_W  = 8,
    parameter int K_W  = 8,
    parameter int RP_W = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic [V_W-1:0]            cfg_v_0,
    input  logic [V_W-1:0]            cfg_v_rest,
    input  logic [V_W-1:0]            cfg_v_leak,
    input  logic [V_W-1:0]            cfg_v_th,
    input  logic [K_W-1:0]            cfg_k_syn,
    input  logic [RP_W-1:0]           cfg_rp,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [I_W-1:0]            in_current,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0]              out_spikes,
    output logic [$clog2(TS+1)-1:0]   out_step,
    output logic                      busy,
    output logic                      done
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int S_W   = $clog2(TS + 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, EMIT} state_t;

    typedef struct packed {
        logic signed [V_W-1:0] v_0;
        logic signed [V_W-1:0] v_rest;
        logic signed [V_W-1:0] v_leak;
        logic signed [V_W-1:0] v_th;
        logic        [K_W-1:0] k_syn;
        logic        [RP_W-1:0] rp;
    } cfg_t;

    state_t                     state;
    cfg_t                       cfg;
    logic [N-1:0][V_W-1:0]      v;
    logic [N-1:0][RP_W-1:0]     r;
    logic [IDX_W-1:0]           idx;
    logic [N-1:0]               spk_acc, spk_nxt;
    logic signed [V_W-1:0]      upd_v;
    logic [RP_W-1:0]            upd_r;
    logic                       upd_fire;
    logic                       last_idx;

    lif_update #(.V_W(V_W), .I_W(I_W), .K_W(K_W), .RP_W(RP_W)) u_upd (
        .v      (v[idx]),
        .r      (r[idx]),
        .cur    (in_current),
        .k_syn  (cfg.k_syn),
        .v_leak (cfg.v_leak),
        .v_rest (cfg.v_rest),
        .v_th   (cfg.v_th),
        .rp     (cfg.rp),
        .v_nxt  (upd_v),
        .r_nxt  (upd_r),
        .fire   (upd_fire)
    );

    assign last_idx = (idx == IDX_W'(N - 1));

    always_comb begin
        spk_nxt      = spk_acc;
        spk_nxt[idx] = upd_fire;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            cfg        <= '0;
            v          <= '0;
            r          <= '0;
            idx        <= '0;
            spk_acc    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_spikes <= '0;
            out_step   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg   <= '{cfg_v_0, cfg_v_rest, cfg_v_leak, cfg_v_th, cfg_k_syn, cfg_rp};
                        busy  <= 1'b1;
                        idx   <= '0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    v[idx] <= cfg.v_0;
                    r[idx] <= '0;
                    if (last_idx) begin
                        idx        <= '0;
                        out_step   <= '0;
                        spk_acc    <= '0;
                        out_spikes <= '0;
                        in_ready   <= 1'b1;
                        state      <= RUN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        v[idx] <= upd_v;
                        r[idx] <= upd_r;
                        if (last_idx) begin
                            out_spikes <= spk_nxt;
                            out_valid  <= 1'b1;
                            in_ready   <= 1'b0;
                            idx        <= '0;
                            state      <= EMIT;
                        end else begin
                            spk_acc <= spk_nxt;
                            idx     <= idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // vector and step index hold until the downstream takes them
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_step == S_W'(TS - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            out_step <= out_step + 1'b1;
                            spk_acc  <= '0;
                            in_ready <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lif_neuron_bank.md
# lif_neuron_bank

Time-multiplexed bank of `N` leaky integrate-and-fire neurons. It runs a configurable number of time steps. Per step it consumes one synaptic current per neuron over a valid/ready stream, and emits an `N`-bit spike vector per step on a second valid/ready stream. It supersedes fixed-size per-neuron instances in the SNN datapath, sitting between the synapse accumulator and the AXI4 spike/neuron-data writer. It adds a threshold, saturating arithmetic, a leak floor and per-neuron refractory counters.

## Interface
- `N`, 2: neurons in the bank.
- `TS`, 5: time steps per run.
- `V_W`, 16: signed membrane-potential width.
- `I_W`, 8: signed synaptic-current width.
- `K_W`, 8: unsigned synaptic-gain width.
- `RP_W`, 4: refractory-counter width.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle run request.
- `cfg_v_0`, `cfg_v_rest`, `cfg_v_leak`, `cfg_v_th`  in  `V_W` each  initial potential, rest potential, leak per step, firing threshold (all signed).
- `cfg_k_syn`  in  `K_W`  synaptic gain.
- `cfg_rp`  in  `RP_W`  refractory period in steps.
- `in_valid`  in  1  synaptic current valid.
- `in_ready`  out  1  bank accepts a current.
- `in_current`  in  `I_W`  signed current for the next neuron in index order.
- `out_valid`  out  1  spike vector valid.
- `out_ready`  in  1  downstream accepts the vector.
- `out_spikes`  out  `N`  bit i = neuron i fired this step.
- `out_step`  out  `$clog2(TS+1)`  index of the step the vector belongs to.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.

## Operation
- Per-neuron state:
  - potential `v[i]`, `V_W` bits signed.
  - refractory counter `r[i]`, `RP_W` bits.
- FSM states IDLE, INIT, RUN, EMIT.
- IDLE:
  - `start` latches all `cfg_*` into shadow registers, sets `busy`, and goes to INIT.
  - `start` outside IDLE is ignored.
- INIT:
  - Writes `v[i]=cfg_v_0`, `r[i]=0` for i=0..N-1, one neuron per cycle (N cycles).
  - Clears the step counter, then goes to RUN with neuron index 0.
- RUN:
  - `in_ready=1`. Each accepted beat (`in_valid&&in_ready`) updates neuron `idx`, then `idx++`.
  - After neuron N-1 is updated, goes to EMIT.
- Update of neuron i with current I:
  - If `r[i]!=0`: `r[i]--`, `v[i]=cfg_v_rest`, spike 0. I is consumed and discarded.
  - Otherwise compute `s = v[i] + cfg_k_syn*I - cfg_v_leak` at full precision (`V_W+K_W+I_W+2` bits signed), then saturate to the signed `V_W` range.
  - If `s < cfg_v_rest`, then `s = cfg_v_rest` (leak floor).
  - If `s >= cfg_v_th`: spike 1, `v[i]=cfg_v_rest`, `r[i]=cfg_rp`. Otherwise spike 0, `v[i]=s`.
  - `cfg_rp=0` means no refractory period.
- EMIT:
  - `out_valid=1`, `in_ready=0`.
  - On `out_ready`: if `out_step==TS-1`, pulse `done`, clear `busy`, go to IDLE. Otherwise `out_step++`, clear the spike accumulator, go to RUN with `idx=0`.

## Timing
- Reset values:
  - `in_ready=0`, `out_valid=0`, `out_spikes=0`, `out_step=0`, `busy=0`, `done=0`.
  - All `v`/`r` cleared; FSM in IDLE.
- Reset asserted mid-run clears everything immediately. No partial vector is emitted, and a later `start` re-runs from scratch.
- `busy` rises the cycle after `start`. INIT lasts N cycles. `in_ready` rises on cycle N+1 after `start`.
- Throughput: one current per cycle while `in_valid` is held.
- `out_valid` rises the cycle after the Nth accepted beat of a step.
- While `out_valid` is high, `out_spikes` and `out_step` are stable until accepted.
- `in_ready` rises the cycle after the EMIT handshake.
- `done` is asserted in the cycle after the final handshake, coincident with `busy` falling.
- `in_valid` outside RUN is ignored; no current is consumed.
- Shadow configuration is immune to `cfg_*` changes during a run.

## Test plan
- Basic LIF sequence:
  - Setup: N=2, TS=5, V_0=0, V_REST=0, V_LEAK=1, K_SYN=2, V_TH=10, RP=1; neuron0 current 3 every step, neuron1 current 0.
  - Required `out_spikes` for steps 0..4: 00,01,00,00,01.
  - Neuron1 stays clamped at 0. `done` pulses once.
- RP=0, same stimulus: neuron0 fires on steps 1 and 3 (vectors 00,01,00,01,00).
- Backpressure: hold `out_ready` low 3 cycles at step 1.
  - `out_valid`, `out_spikes=01` and `out_step=1` stay stable.
  - `in_ready` stays 0; no beat is lost.
- Saturation: V_W=8, V_TH=127, K_SYN=255, I=127, V_0=100. Sum saturates to 127 and neuron fires; no wrap to negative.
- Reset during step 2, then re-start: all outputs are 0 immediately, and the rerun reproduces the identical vector sequence.
- `start` pulsed while `busy`: ignored, with no restart and no change to `out_step`.
